// File: rtl/fetch_unit.sv
// In-order instruction fetch: PC register, credit-limited imem requests, and an
// instruction FIFO that feeds decode. Optional macro: FETCH_ALIGN_CHECK_EN.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter int          CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic        fetch_fault
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, STALL} state_e;

    state_e           state_q;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] inflight_q, inflight_d;
    logic [CNT_W-1:0] stale_q, stale_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic             fault_q, fault_d;
    logic [CNT_W:0]   occ_next;
    logic [31:0]      target;
    logic             target_bad;
    logic             req_fire, push, pop;

    logic [31:0] data_mem [FIFO_DEPTH];
    logic [31:0] pc_mem   [FIFO_DEPTH];

`ifdef FETCH_ALIGN_CHECK_EN
    assign target     = redirect_pc;
    assign target_bad = |redirect_pc[1:0];
    assign fetch_fault = fault_q;
`else
    assign target     = redirect_pc & 32'hFFFF_FFFC;
    assign target_bad = 1'b0;
`endif

    assign imem_req_valid = (state_q == RUN) && !redirect_valid && !fault_q;
    assign imem_req_addr  = pc_q;
    assign inst_valid     = (count_q != '0);
    assign inst_data      = inst_valid ? data_mem[rd_ptr_q] : 32'h0;
    assign inst_pc        = inst_valid ? pc_mem[rd_ptr_q]   : 32'h0;

    assign req_fire = imem_req_valid && imem_req_ready;
    assign pop      = inst_valid && inst_ready;
    // Words answering requests issued before the latest redirect are dropped.
    assign push     = imem_resp_valid && (stale_q == '0) && !redirect_valid;

    always_comb begin
        pc_d       = pc_q;
        resp_pc_d  = resp_pc_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        fault_d    = fault_q;
        stale_d    = stale_q;
        inflight_d = inflight_q + CNT_W'(req_fire) - CNT_W'(imem_resp_valid);

        if (redirect_valid) begin
            pc_d      = target;
            resp_pc_d = target;
            count_d   = '0;
            rd_ptr_d  = '0;
            wr_ptr_d  = '0;
            fault_d   = target_bad;
            stale_d   = inflight_d;
        end else begin
            if (req_fire) pc_d = pc_q + 32'd4;
            if (imem_resp_valid && (stale_q != '0)) stale_d = stale_q - CNT_W'(1);
            if (push) begin
                resp_pc_d = resp_pc_q + 32'd4;
                wr_ptr_d  = wr_ptr_q + PTR_W'(1);
            end
            if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end

        occ_next = {1'b0, count_d} + {1'b0, inflight_d};
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            count_q    <= '0;
            inflight_q <= '0;
            stale_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            fault_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE:       state_q <= RUN;
                RUN, STALL: state_q <= (occ_next < (CNT_W+1)'(FIFO_DEPTH)) ? RUN : STALL;
                default:    state_q <= IDLE;
            endcase
            pc_q       <= pc_d;
            resp_pc_q  <= resp_pc_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            stale_q    <= stale_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            fault_q    <= fault_d;
        end
    end

    // NOTE: storage is not reset; the outputs are masked by inst_valid instead.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_q] <= imem_resp_data;
            pc_mem[wr_ptr_q]   <= resp_pc_q;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: in-order imem responder with hold control,
// passive decode monitor, one task per scenario.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        fetch_fault;
`endif

    int checks   = 0;
    int failures = 0;
    logic        resp_en;
    logic [31:0] rq[$];
    logic [31:0] got_pc[$];
    logic [31:0] got_data[$];
    logic [31:0] req_log[$];

    fetch_unit dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_data(inst_data), .inst_pc(inst_pc)
`ifdef FETCH_ALIGN_CHECK_EN
        , .fetch_fault(fetch_fault)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    // imem model: one-cycle latency, in order, responses can be held with resp_en=0.
    initial begin
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        forever begin
            @(negedge clk);
            if (rst) rq.delete();
            else begin
                if (imem_resp_valid && rq.size() > 0) rq.delete(0);
                if (imem_req_valid && imem_req_ready) rq.push_back(imem_req_addr);
            end
            @(posedge clk);
            #1;
            if (!rst && resp_en && rq.size() > 0) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = mem_word(rq[0]);
            end else begin
                imem_resp_valid = 1'b0;
                imem_resp_data  = 32'h0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (inst_valid && inst_ready) begin
                got_pc.push_back(inst_pc);
                got_data.push_back(inst_data);
            end
            if (imem_req_valid && imem_req_ready) req_log.push_back(imem_req_addr);
        end
    end

    task automatic clear_logs();
        got_pc.delete();
        got_data.delete();
        req_log.delete();
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic en);
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        resp_en        = en;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        clear_logs();
    endtask

    // One-cycle redirect; request must be gated in that cycle and the FIFO empty after it.
    task automatic do_redirect(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        @(negedge clk);
        checks++;
        if (imem_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL redir_req_gated: got %b want 0", imem_req_valid);
        end
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        clear_logs();
        @(negedge clk);
        checks++;
        if (inst_valid !== 1'b0) begin
            failures++;
            $display("FAIL redir_flush: inst_valid got %b want 0", inst_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
        imem_req_ready = 1'b1; inst_ready = 1'b1; resp_en = 1'b1;
        @(negedge clk);
        checks++;
        if ({imem_req_valid, inst_valid, inst_data, inst_pc} !== 66'h0) begin
            failures++;
            $display("FAIL reset_outputs: got req=%b iv=%b data=%h pc=%h want all 0",
                     imem_req_valid, inst_valid, inst_data, inst_pc);
        end
`ifdef FETCH_ALIGN_CHECK_EN
        checks++;
        if (fetch_fault !== 1'b0) begin
            failures++;
            $display("FAIL reset_fault: got %b want 0", fetch_fault);
        end
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_logs();
        @(negedge clk);
        checks++;
        if (imem_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL idle_no_req: got %b want 0", imem_req_valid);
        end
        @(negedge clk);
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
            failures++;
            $display("FAIL first_req: got v=%b addr=%h want v=1 addr=00000000", imem_req_valid, imem_req_addr);
        end
        @(negedge clk);
        checks++;
        if (inst_valid !== 1'b0) begin
            failures++;
            $display("FAIL latency_early: inst_valid got %b want 0", inst_valid);
        end
        @(negedge clk);
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst_data !== mem_word(32'h0)) begin
            failures++;
            $display("FAIL latency_first: got v=%b pc=%h data=%h want v=1 pc=0 data=%h",
                     inst_valid, inst_pc, inst_data, mem_word(32'h0));
        end
    endtask

    task automatic test_stream();
        do_reset(1'b1);
        tick(30);
        checks++;
        if (got_pc.size() < 8 || req_log.size() < 8) begin
            failures++;
            $display("FAIL stream_count: got %0d words %0d reqs want >= 8", got_pc.size(), req_log.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (got_pc[i] !== 32'(4*i) || got_data[i] !== mem_word(32'(4*i)) || req_log[i] !== 32'(4*i)) begin
                    failures++;
                    $display("FAIL stream_%0d: got pc=%h data=%h req=%h want pc=%h data=%h",
                             i, got_pc[i], got_data[i], req_log[i], 32'(4*i), mem_word(32'(4*i)));
                end
            end
        end
    endtask

    task automatic test_req_stall();
        do_reset(1'b1);
        imem_req_ready = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
                failures++;
                $display("FAIL req_hold_%0d: got v=%b addr=%h want v=1 addr=0", i, imem_req_valid, imem_req_addr);
            end
        end
        @(posedge clk);
        #1;
        imem_req_ready = 1'b1;
        tick(12);
        checks++;
        if (got_pc.size() < 2 || got_pc[0] !== 32'h0 || got_pc[1] !== 32'h4) begin
            failures++;
            $display("FAIL req_hold_resume: got %0d words first=%h want 0,4",
                     got_pc.size(), (got_pc.size() > 0) ? got_pc[0] : 32'hx);
        end
    endtask

    task automatic test_backpressure();
        do_reset(1'b1);
        inst_ready = 1'b0;
        tick(12);
        @(negedge clk);
        checks++;
        if (inst_valid !== 1'b1 || imem_req_valid !== 1'b0 || req_log.size() != 2) begin
            failures++;
            $display("FAIL bp_hold: got iv=%b req=%b reqs=%0d want iv=1 req=0 reqs=2",
                     inst_valid, imem_req_valid, req_log.size());
        end
        checks++;
        if (inst_pc !== 32'h0 || inst_data !== mem_word(32'h0)) begin
            failures++;
            $display("FAIL bp_head: got pc=%h data=%h want pc=0 data=%h", inst_pc, inst_data, mem_word(32'h0));
        end
        @(posedge clk);
        #1;
        inst_ready = 1'b1;
        tick(30);
        checks++;
        if (got_pc.size() < 8) begin
            failures++;
            $display("FAIL bp_count: got %0d words want >= 8", got_pc.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (got_pc[i] !== 32'(4*i) || got_data[i] !== mem_word(32'(4*i))) begin
                    failures++;
                    $display("FAIL bp_resume_%0d: got pc=%h data=%h want pc=%h", i, got_pc[i], got_data[i], 32'(4*i));
                end
            end
        end
    endtask

    task automatic test_redirect_inflight();
        do_reset(1'b0);
        tick(5);
        do_redirect(32'h100);
        resp_en = 1'b1;
        tick(20);
        checks++;
        if (got_pc.size() < 2 || got_pc[0] !== 32'h100 || got_data[0] !== mem_word(32'h100) || got_pc[1] !== 32'h104) begin
            failures++;
            $display("FAIL redir_inflight: got %0d words first pc=%h data=%h want pc=100 data=%h",
                     got_pc.size(), (got_pc.size() > 0) ? got_pc[0] : 32'hx,
                     (got_data.size() > 0) ? got_data[0] : 32'hx, mem_word(32'h100));
        end
    endtask

    task automatic test_redirect_with_resp();
        do_reset(1'b0);
        tick(4);
        @(negedge clk);
        resp_en = 1'b1;
        @(posedge clk);
        #1;
        do_redirect(32'h240);
        tick(20);
        checks++;
        if (got_pc.size() < 2 || got_pc[0] !== 32'h240 || got_data[0] !== mem_word(32'h240) || got_pc[1] !== 32'h244) begin
            failures++;
            $display("FAIL redir_same_cycle: got %0d words first pc=%h data=%h want pc=240 data=%h",
                     got_pc.size(), (got_pc.size() > 0) ? got_pc[0] : 32'hx,
                     (got_data.size() > 0) ? got_data[0] : 32'hx, mem_word(32'h240));
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp [4];
        exp[0] = 32'hFFFF_FFF8; exp[1] = 32'hFFFF_FFFC; exp[2] = 32'h0; exp[3] = 32'h4;
        do_reset(1'b1);
        tick(6);
        do_redirect(32'hFFFF_FFF8);
        tick(25);
        checks++;
        if (got_pc.size() < 4 || req_log.size() < 4) begin
            failures++;
            $display("FAIL wrap_count: got %0d words %0d reqs want >= 4", got_pc.size(), req_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (req_log[i] !== exp[i] || got_pc[i] !== exp[i] || got_data[i] !== mem_word(exp[i])) begin
                    failures++;
                    $display("FAIL wrap_%0d: got req=%h pc=%h data=%h want %h", i, req_log[i], got_pc[i], got_data[i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset(1'b1);
        tick(8);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        @(posedge clk);
        #1;
        redirect_pc = 32'h404;
        @(negedge clk);
        checks++;
        if (imem_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_req_gated: got %b want 0", imem_req_valid);
        end
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        clear_logs();
        tick(25);
        checks++;
        if (got_pc.size() < 2 || got_pc[0] !== 32'h404 || got_data[0] !== mem_word(32'h404) || got_pc[1] !== 32'h408) begin
            failures++;
            $display("FAIL b2b_redirect: got %0d words first pc=%h want 404,408",
                     got_pc.size(), (got_pc.size() > 0) ? got_pc[0] : 32'hx);
        end
    endtask

    task automatic test_async_reset();
        do_reset(1'b1);
        tick(10);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({imem_req_valid, inst_valid, inst_data, inst_pc} !== 66'h0) begin
            failures++;
            $display("FAIL async_reset: got req=%b iv=%b data=%h pc=%h want all 0",
                     imem_req_valid, inst_valid, inst_data, inst_pc);
        end
    endtask

    task automatic test_align();
        do_reset(1'b1);
        tick(6);
        do_redirect(32'h102);
`ifdef FETCH_ALIGN_CHECK_EN
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (fetch_fault !== 1'b1 || imem_req_valid !== 1'b0) begin
                failures++;
                $display("FAIL align_fault_%0d: got fault=%b req=%b want fault=1 req=0", i, fetch_fault, imem_req_valid);
            end
        end
        @(posedge clk);
        #1;
        do_redirect(32'h200);
        checks++;
        if (fetch_fault !== 1'b0) begin
            failures++;
            $display("FAIL align_clear: got %b want 0", fetch_fault);
        end
        tick(20);
        checks++;
        if (got_pc.size() < 1 || got_pc[0] !== 32'h200 || got_data[0] !== mem_word(32'h200)) begin
            failures++;
            $display("FAIL align_refetch: got %0d words first=%h want 200",
                     got_pc.size(), (got_pc.size() > 0) ? got_pc[0] : 32'hx);
        end
`else
        tick(20);
        checks++;
        if (got_pc.size() < 2 || req_log.size() < 1 || got_pc[0] !== 32'h100 || got_pc[1] !== 32'h104 || req_log[0] !== 32'h100) begin
            failures++;
            $display("FAIL align_ignored: got %0d words first=%h want 100,104",
                     got_pc.size(), (got_pc.size() > 0) ? got_pc[0] : 32'hx);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_stream();
        test_req_stall();
        test_backpressure();
        test_redirect_inflight();
        test_redirect_with_resp();
        test_wrap();
        test_back_to_back();
        test_async_reset();
        test_align();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
